// File: rtl/ls_stage.sv
// Load/store pipeline stage: passes ALU results through, or issues one bus
// request per memory op and formats the response into a writeback beat.
module ls_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m_valid_i,
  output logic            m_ready_o,
  input  logic            m_wenReg_i,
  input  logic [4:0]      m_rd_i,
  input  logic [XLEN-1:0] m_res_i,
  input  logic [XLEN-1:0] m_src1_i,
  input  logic            m_wenMem_i,
  input  logic            m_renMem_i,
  input  logic            m_is_load_signed_i,
  input  logic [3:0]      m_mask_i,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic            req_wen_o,
  output logic [XLEN-1:0] req_addr_o,
  output logic [XLEN-1:0] req_wdata_o,
  output logic [3:0]      req_wstrb_o,
  input  logic            rsp_valid_i,
  output logic            rsp_ready_o,
  input  logic [XLEN-1:0] rsp_rdata_i,
  input  logic            rsp_err_i,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output logic            w_wenReg_o,
  output logic [4:0]      w_rd_o,
  output logic [XLEN-1:0] w_data_o,
  output logic            w_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_e;

  state_e          state_q, state_d;
  logic            run_q;
  logic            wen_reg_q, wen_reg_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic            wen_mem_q, wen_mem_d;
  logic            signed_q, signed_d;
  logic [3:0]      mask_q, mask_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic            w_err_q, w_err_d;
  logic            w_wen_q, w_wen_d;

  logic            accept;
  logic            m_mem;
  logic            m_illegal;
  logic [XLEN-1:0] rsp_shift;
  logic [XLEN-1:0] load_data;

  // run_q keeps m_ready_o low until the first edge after reset releases
  assign m_ready_o = (state_q == IDLE) & run_q;
  assign accept    = m_valid_i & m_ready_o;
  assign m_mem     = m_wenMem_i | m_renMem_i;
  assign m_illegal = m_mem & ((m_wenMem_i & m_renMem_i) |
                              ((m_mask_i == 4'b0011) & m_res_i[0]) |
                              ((m_mask_i == 4'b1111) & (|m_res_i[1:0])));

  assign rsp_shift = rsp_rdata_i >> {res_q[1:0], 3'b000};

  always_comb begin
    case (mask_q)
      4'b0001: load_data = {{(XLEN-8){signed_q & rsp_shift[7]}}, rsp_shift[7:0]};
      4'b0011: load_data = {{(XLEN-16){signed_q & rsp_shift[15]}}, rsp_shift[15:0]};
      default: load_data = rsp_shift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wen_reg_d = wen_reg_q;
    rd_d      = rd_q;
    res_d     = res_q;
    src1_d    = src1_q;
    wen_mem_d = wen_mem_q;
    signed_d  = signed_q;
    mask_d    = mask_q;
    w_data_d  = w_data_q;
    w_err_d   = w_err_q;
    w_wen_d   = w_wen_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wen_reg_d = m_wenReg_i;
          rd_d      = m_rd_i;
          res_d     = m_res_i;
          src1_d    = m_src1_i;
          wen_mem_d = m_wenMem_i;
          signed_d  = m_is_load_signed_i;
          mask_d    = m_mask_i;
          if (!m_mem) begin
            state_d  = WB;
            w_data_d = m_res_i;
            w_wen_d  = m_wenReg_i;
            w_err_d  = 1'b0;
          end else if (m_illegal) begin
            state_d  = WB;
            w_data_d = '0;
            w_wen_d  = 1'b0;
            w_err_d  = 1'b1;
          end else begin
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (req_ready_i) state_d = RESP;
      end
      RESP: begin
        if (rsp_valid_i) begin
          state_d = WB;
          if (rsp_err_i) begin
            w_data_d = '0;
            w_wen_d  = 1'b0;
            w_err_d  = 1'b1;
          end else begin
            w_data_d = wen_mem_q ? '0 : load_data;
            w_wen_d  = wen_reg_q;
            w_err_d  = 1'b0;
          end
        end
      end
      WB: begin
        if (w_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      wen_reg_q <= 1'b0;
      rd_q      <= '0;
      res_q     <= '0;
      src1_q    <= '0;
      wen_mem_q <= 1'b0;
      signed_q  <= 1'b0;
      mask_q    <= '0;
      w_data_q  <= '0;
      w_err_q   <= 1'b0;
      w_wen_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      wen_reg_q <= wen_reg_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      src1_q    <= src1_d;
      wen_mem_q <= wen_mem_d;
      signed_q  <= signed_d;
      mask_q    <= mask_d;
      w_data_q  <= w_data_d;
      w_err_q   <= w_err_d;
      w_wen_q   <= w_wen_d;
    end
  end

  assign req_valid_o = (state_q == REQ);
  assign req_wen_o   = req_valid_o & wen_mem_q;
  assign req_addr_o  = req_valid_o ? res_q : '0;
  assign req_wstrb_o = req_wen_o ? (mask_q << res_q[1:0]) : 4'b0000;
  assign req_wdata_o = req_valid_o ? (src1_q << {res_q[1:0], 3'b000}) : '0;
  assign rsp_ready_o = (state_q == RESP);
  assign w_valid_o   = (state_q == WB);
  assign w_wenReg_o  = w_wen_q;
  assign w_rd_o      = rd_q;
  assign w_data_o    = w_data_q;
  assign w_err_o     = w_err_q;

endmodule

// File: tb/tb_ls_stage.sv
// Directed bench for ls_stage: ALU pass-through, loads, stores, illegal ops,
// response errors and reset while a response is outstanding.
module tb_ls_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        m_valid_i = 1'b0;
  logic        m_ready_o;
  logic        m_wenReg_i = 1'b0;
  logic [4:0]  m_rd_i = '0;
  logic [31:0] m_res_i = '0;
  logic [31:0] m_src1_i = '0;
  logic        m_wenMem_i = 1'b0;
  logic        m_renMem_i = 1'b0;
  logic        m_is_load_signed_i = 1'b0;
  logic [3:0]  m_mask_i = '0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic        req_wen_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_wstrb_o;
  logic        rsp_valid_i = 1'b0;
  logic        rsp_ready_o;
  logic [31:0] rsp_rdata_i = '0;
  logic        rsp_err_i = 1'b0;
  logic        w_valid_o;
  logic        w_ready_i = 1'b0;
  logic        w_wenReg_o;
  logic [4:0]  w_rd_o;
  logic [31:0] w_data_o;
  logic        w_err_o;

  int vectors = 0;
  int miscompares = 0;

  ls_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
    .m_wenReg_i(m_wenReg_i), .m_rd_i(m_rd_i),
    .m_res_i(m_res_i), .m_src1_i(m_src1_i),
    .m_wenMem_i(m_wenMem_i), .m_renMem_i(m_renMem_i),
    .m_is_load_signed_i(m_is_load_signed_i), .m_mask_i(m_mask_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_wen_o(req_wen_o), .req_addr_o(req_addr_o),
    .req_wdata_o(req_wdata_o), .req_wstrb_o(req_wstrb_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_rdata_i(rsp_rdata_i), .rsp_err_i(rsp_err_i),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_wenReg_o(w_wenReg_o), .w_rd_o(w_rd_o),
    .w_data_o(w_data_o), .w_err_o(w_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single edge; caller guarantees the stage is in IDLE.
  task automatic send_op(input logic wenreg, input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] src1, input logic wenmem, input logic renmem,
                         input logic sgn, input logic [3:0] mask);
    m_valid_i = 1'b1; m_wenReg_i = wenreg; m_rd_i = rd; m_res_i = res; m_src1_i = src1;
    m_wenMem_i = wenmem; m_renMem_i = renmem; m_is_load_signed_i = sgn; m_mask_i = mask;
    tick();
    m_valid_i = 1'b0;
    $display("op res=%h src1=%h wen=%b ren=%b sgn=%b mask=%b rd=%0d", res, src1, wenmem, renmem, sgn, mask, rd);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    vectors++; if (m_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_m_ready: got %b expected 0", m_ready_o); end
    vectors++; if (req_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b expected 0", req_valid_o); end
    vectors++; if (rsp_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_ready: got %b expected 0", rsp_ready_o); end
    vectors++; if (w_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_w_valid: got %b expected 0", w_valid_o); end
    vectors++; if ({w_data_o, req_addr_o, req_wdata_o} !== 96'h0) begin miscompares++; $display("FAIL rst_data: got %h/%h/%h expected 0", w_data_o, req_addr_o, req_wdata_o); end
    rst_i = 1'b0;
    tick();
    vectors++; if (m_ready_o !== 1'b1) begin miscompares++; $display("FAIL post_rst_m_ready: got %b expected 1", m_ready_o); end
    $display("txn reset released");
  endtask

  task automatic test_alu();
    w_ready_i = 1'b0;
    send_op(1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      vectors++; if (w_valid_o !== 1'b1) begin miscompares++; $display("FAIL alu_w_valid[%0d]: got %b expected 1", k, w_valid_o); end
      vectors++; if (w_data_o !== 32'h00001234) begin miscompares++; $display("FAIL alu_w_data[%0d]: got %h expected 00001234", k, w_data_o); end
      vectors++; if ({w_rd_o, w_wenReg_o, w_err_o} !== {5'd5, 1'b1, 1'b0}) begin miscompares++; $display("FAIL alu_w_ctl[%0d]: got rd=%0d wen=%b err=%b expected rd=5 wen=1 err=0", k, w_rd_o, w_wenReg_o, w_err_o); end
      vectors++; if (req_valid_o !== 1'b0) begin miscompares++; $display("FAIL alu_no_req[%0d]: got %b expected 0", k, req_valid_o); end
      if (k < 3) tick();
    end
    w_ready_i = 1'b1;
    tick();
    w_ready_i = 1'b0;
    vectors++; if ({w_valid_o, m_ready_o} !== 2'b01) begin miscompares++; $display("FAIL alu_done: got w_valid=%b m_ready=%b expected 0/1", w_valid_o, m_ready_o); end
    $display("txn alu res=00001234 rd=5");
  endtask

  task automatic test_back_to_back();
    send_op(1'b1, 5'd7, 32'h0000_00AA, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111);
    // Present the next op in the same cycle the WB handshake completes.
    m_valid_i = 1'b1; m_wenReg_i = 1'b1; m_rd_i = 5'd8; m_res_i = 32'h0000_0055;
    w_ready_i = 1'b1;
    vectors++; if (m_ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_no_accept_in_wb: got %b expected 0", m_ready_o); end
    tick();
    w_ready_i = 1'b0;
    vectors++; if ({m_ready_o, w_valid_o} !== 2'b10) begin miscompares++; $display("FAIL b2b_idle: got m_ready=%b w_valid=%b expected 1/0", m_ready_o, w_valid_o); end
    tick();
    m_valid_i = 1'b0;
    vectors++; if ({w_valid_o, w_data_o, w_rd_o} !== {1'b1, 32'h55, 5'd8}) begin miscompares++; $display("FAIL b2b_second: got v=%b data=%h rd=%0d expected 1/00000055/8", w_valid_o, w_data_o, w_rd_o); end
    w_ready_i = 1'b1;
    tick();
    w_ready_i = 1'b0;
    $display("txn back_to_back 000000aa then 00000055");
  endtask

  task automatic test_load();
    logic [31:0] la[6];
    logic [3:0]  lm[6];
    logic        ls[6];
    logic [31:0] lr[6];
    logic [31:0] le[6];
    la[0] = 32'h80000003; lm[0] = 4'b0001; ls[0] = 1'b1; lr[0] = 32'h80FFFFFF; le[0] = 32'hFFFFFF80;
    la[1] = 32'h80000003; lm[1] = 4'b0001; ls[1] = 1'b0; lr[1] = 32'h80FFFFFF; le[1] = 32'h00000080;
    la[2] = 32'h80000002; lm[2] = 4'b0011; ls[2] = 1'b1; lr[2] = 32'h80011234; le[2] = 32'hFFFF8001;
    la[3] = 32'h80000002; lm[3] = 4'b0011; ls[3] = 1'b0; lr[3] = 32'h80011234; le[3] = 32'h00008001;
    la[4] = 32'h80000000; lm[4] = 4'b1111; ls[4] = 1'b1; lr[4] = 32'hDEADBEEF; le[4] = 32'hDEADBEEF;
    la[5] = 32'h80000001; lm[5] = 4'b0001; ls[5] = 1'b1; lr[5] = 32'h00007F00; le[5] = 32'h0000007F;
    for (int i = 0; i < 6; i++) begin
      req_ready_i = 1'b1;
      send_op(1'b1, 5'(i + 1), la[i], 32'hFFFF_FFFF, 1'b0, 1'b1, ls[i], lm[i]);
      vectors++; if ({req_valid_o, req_wen_o, req_wstrb_o} !== 6'b1_0_0000) begin miscompares++; $display("FAIL ld%0d_req: got v=%b wen=%b strb=%b expected 1/0/0000", i, req_valid_o, req_wen_o, req_wstrb_o); end
      vectors++; if (req_addr_o !== la[i]) begin miscompares++; $display("FAIL ld%0d_addr: got %h expected %h", i, req_addr_o, la[i]); end
      tick();
      req_ready_i = 1'b0;
      vectors++; if ({rsp_ready_o, req_valid_o} !== 2'b10) begin miscompares++; $display("FAIL ld%0d_resp_state: got rsp_ready=%b req_valid=%b expected 1/0", i, rsp_ready_o, req_valid_o); end
      rsp_valid_i = 1'b1; rsp_rdata_i = lr[i]; rsp_err_i = 1'b0;
      tick();
      rsp_valid_i = 1'b0;
      vectors++; if (w_valid_o !== 1'b1) begin miscompares++; $display("FAIL ld%0d_latency: got w_valid=%b expected 1", i, w_valid_o); end
      vectors++; if (w_data_o !== le[i]) begin miscompares++; $display("FAIL ld%0d_data: got %h expected %h", i, w_data_o, le[i]); end
      vectors++; if ({w_wenReg_o, w_err_o, w_rd_o} !== {1'b1, 1'b0, 5'(i + 1)}) begin miscompares++; $display("FAIL ld%0d_ctl: got wen=%b err=%b rd=%0d expected 1/0/%0d", i, w_wenReg_o, w_err_o, w_rd_o, i + 1); end
      w_ready_i = 1'b1;
      tick();
      w_ready_i = 1'b0;
      $display("txn load addr=%h rdata=%h data=%h", la[i], lr[i], w_data_o);
    end
  endtask

  task automatic test_store();
    logic [31:0] sa[3];
    logic [31:0] sd[3];
    logic [3:0]  sm[3];
    logic        sw[3];
    int          wt[3];
    logic [3:0]  es[3];
    logic [31:0] ed[3];
    sa[0] = 32'h80000002; sd[0] = 32'h0000ABCD; sm[0] = 4'b0011; sw[0] = 1'b0; wt[0] = 2; es[0] = 4'b1100; ed[0] = 32'hABCD0000;
    sa[1] = 32'h80000001; sd[1] = 32'h112233EF; sm[1] = 4'b0001; sw[1] = 1'b1; wt[1] = 0; es[1] = 4'b0010; ed[1] = 32'h2233EF00;
    sa[2] = 32'h80000000; sd[2] = 32'hCAFEF00D; sm[2] = 4'b1111; sw[2] = 1'b1; wt[2] = 1; es[2] = 4'b1111; ed[2] = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      req_ready_i = 1'b0;
      send_op(sw[i], 5'd12, sa[i], sd[i], 1'b1, 1'b0, 1'b0, sm[i]);
      rsp_valid_i = 1'b1; rsp_err_i = 1'b0; rsp_rdata_i = 32'h5A5A5A5A;
      for (int k = 0; k <= wt[i]; k++) begin
        vectors++; if ({req_valid_o, req_wen_o, rsp_ready_o} !== 3'b110) begin miscompares++; $display("FAIL st%0d_req_hold[%0d]: got v=%b wen=%b rsp_ready=%b expected 1/1/0", i, k, req_valid_o, req_wen_o, rsp_ready_o); end
        vectors++; if (req_addr_o !== sa[i]) begin miscompares++; $display("FAIL st%0d_addr[%0d]: got %h expected %h", i, k, req_addr_o, sa[i]); end
        vectors++; if (req_wstrb_o !== es[i]) begin miscompares++; $display("FAIL st%0d_wstrb[%0d]: got %b expected %b", i, k, req_wstrb_o, es[i]); end
        vectors++; if (req_wdata_o !== ed[i]) begin miscompares++; $display("FAIL st%0d_wdata[%0d]: got %h expected %h", i, k, req_wdata_o, ed[i]); end
        if (k == wt[i]) req_ready_i = 1'b1;
        tick();
      end
      req_ready_i = 1'b0;
      vectors++; if ({req_valid_o, rsp_ready_o} !== 2'b01) begin miscompares++; $display("FAIL st%0d_resp_state: got req_valid=%b rsp_ready=%b expected 0/1", i, req_valid_o, rsp_ready_o); end
      tick();
      rsp_valid_i = 1'b0;
      vectors++; if ({w_valid_o, w_data_o, w_wenReg_o, w_err_o} !== {1'b1, 32'h0, sw[i], 1'b0}) begin miscompares++; $display("FAIL st%0d_wb: got v=%b data=%h wen=%b err=%b expected 1/00000000/%b/0", i, w_valid_o, w_data_o, w_wenReg_o, w_err_o, sw[i]); end
      w_ready_i = 1'b1;
      tick();
      w_ready_i = 1'b0;
      $display("txn store addr=%h wdata=%h wstrb=%b", sa[i], ed[i], es[i]);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ia[4];
    logic [3:0]  im[4];
    logic        iw[4];
    logic        ir[4];
    ia[0] = 32'h80000001; im[0] = 4'b1111; iw[0] = 1'b0; ir[0] = 1'b1;
    ia[1] = 32'h80000003; im[1] = 4'b0011; iw[1] = 1'b0; ir[1] = 1'b1;
    ia[2] = 32'h80000004; im[2] = 4'b1111; iw[2] = 1'b1; ir[2] = 1'b1;
    ia[3] = 32'h80000001; im[3] = 4'b0011; iw[3] = 1'b1; ir[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_ready_i = 1'b1;
      send_op(1'b1, 5'd20, ia[i], 32'h12345678, iw[i], ir[i], 1'b1, im[i]);
      vectors++; if (req_valid_o !== 1'b0) begin miscompares++; $display("FAIL ill%0d_no_req: got %b expected 0", i, req_valid_o); end
      vectors++; if ({w_valid_o, w_err_o, w_wenReg_o, w_data_o} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin miscompares++; $display("FAIL ill%0d_wb: got v=%b err=%b wen=%b data=%h expected 1/1/0/00000000", i, w_valid_o, w_err_o, w_wenReg_o, w_data_o); end
      req_ready_i = 1'b0;
      w_ready_i = 1'b1;
      tick();
      w_ready_i = 1'b0;
      $display("txn illegal addr=%h mask=%b", ia[i], im[i]);
    end
  endtask

  task automatic test_rsp_err();
    req_ready_i = 1'b1;
    send_op(1'b1, 5'd4, 32'h80000010, 32'h0, 1'b0, 1'b1, 1'b0, 4'b1111);
    tick();
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b1; rsp_err_i = 1'b1; rsp_rdata_i = 32'h12345678;
    tick();
    rsp_valid_i = 1'b0; rsp_err_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++; if ({w_valid_o, w_err_o, w_wenReg_o, w_data_o} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin miscompares++; $display("FAIL rsperr_wb[%0d]: got v=%b err=%b wen=%b data=%h expected 1/1/0/00000000", k, w_valid_o, w_err_o, w_wenReg_o, w_data_o); end
      if (k == 0) tick();
    end
    w_ready_i = 1'b1;
    tick();
    w_ready_i = 1'b0;
    vectors++; if ({m_ready_o, w_valid_o} !== 2'b10) begin miscompares++; $display("FAIL rsperr_idle: got m_ready=%b w_valid=%b expected 1/0", m_ready_o, w_valid_o); end
    $display("txn load with response error");
  endtask

  task automatic test_reset_in_resp();
    req_ready_i = 1'b1;
    send_op(1'b1, 5'd9, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 4'b1111);
    tick();
    req_ready_i = 1'b0;
    vectors++; if (rsp_ready_o !== 1'b1) begin miscompares++; $display("FAIL rstresp_in_resp: got %b expected 1", rsp_ready_o); end
    #2 rst_i = 1'b1;
    #1;
    vectors++; if ({rsp_ready_o, w_valid_o, m_ready_o, req_valid_o} !== 4'b0000) begin miscompares++; $display("FAIL rstresp_async: got rsp_ready=%b w_valid=%b m_ready=%b req_valid=%b expected 0000", rsp_ready_o, w_valid_o, m_ready_o, req_valid_o); end
    rsp_valid_i = 1'b1; rsp_rdata_i = 32'hFEEDFACE;
    tick();
    rst_i = 1'b0;
    tick();
    vectors++; if ({m_ready_o, w_valid_o, rsp_ready_o} !== 3'b100) begin miscompares++; $display("FAIL rstresp_release: got m_ready=%b w_valid=%b rsp_ready=%b expected 1/0/0", m_ready_o, w_valid_o, rsp_ready_o); end
    tick();
    vectors++; if ({w_valid_o, w_data_o} !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL rstresp_late_rsp: got v=%b data=%h expected 0/00000000", w_valid_o, w_data_o); end
    rsp_valid_i = 1'b0;
    send_op(1'b1, 5'd3, 32'h0BADF00D, 32'h0, 1'b0, 1'b0, 1'b0, 4'b1111);
    vectors++; if ({w_valid_o, w_data_o, w_rd_o} !== {1'b1, 32'h0BADF00D, 5'd3}) begin miscompares++; $display("FAIL rstresp_next_op: got v=%b data=%h rd=%0d expected 1/0badf00d/3", w_valid_o, w_data_o, w_rd_o); end
    w_ready_i = 1'b1;
    tick();
    w_ready_i = 1'b0;
    $display("txn reset during response, then alu 0badf00d");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
    test_illegal();
    test_rsp_err();
    test_reset_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ls_stage.md
LS_STAGE -- requirements
Module: ls_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of data and address paths; only 32 is required.
REQ-002 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-high.
REQ-003 SHALL have ports: m_valid_i in 1, upstream op valid; m_ready_o out 1, ready to accept.
REQ-004 SHALL have ports: m_wenReg_i in 1, writes rd; m_rd_i in 5, destination register.
REQ-005 SHALL have ports: m_res_i in 32, ALU result, or memory address when a memory op; m_src1_i in 32, store data.
REQ-006 SHALL have ports: m_wenMem_i in 1, store; m_renMem_i in 1, load; m_is_load_signed_i in 1, sign-extend load; m_mask_i in 4, size (0001 byte, 0011 half, 1111 word).
REQ-007 SHALL have ports: req_valid_o out 1; req_ready_i in 1; req_wen_o out 1; req_addr_o out 32; req_wdata_o out 32; req_wstrb_o out 4.
REQ-008 SHALL have ports: rsp_valid_i in 1; rsp_ready_o out 1; rsp_rdata_i in 32; rsp_err_i in 1.
REQ-009 SHALL have ports: w_valid_o out 1; w_ready_i in 1; w_wenReg_o out 1; w_rd_o out 5; w_data_o out 32; w_err_o out 1.

Function
REQ-010 SHALL implement an FSM with states IDLE, REQ, RESP and WB.
REQ-011 SHALL drive m_ready_o=1 only in IDLE; an op is accepted when m_valid_i & m_ready_o, and all m_* fields are registered on that edge.
REQ-012 SHALL, on accept of an op with m_wenMem_i=0 and m_renMem_i=0, go to WB, with w_data_o=m_res_i and w_valid_o high in the next cycle.
REQ-013 SHALL, on accept of a load or store, go to REQ, unless REQ-018 applies.
REQ-014 SHALL, in REQ, hold req_valid_o=1 with stable req_* until req_ready_i=1, then go to RESP.
REQ-015 SHALL drive req_addr_o = registered res, unaligned, byte address.
REQ-016 SHALL drive req_wen_o = store flag and req_wstrb_o = mask << addr[1:0] (store; 0 for load).
REQ-017 SHALL drive req_wdata_o = src1 << (8*addr[1:0]).
REQ-018 SHALL treat an op as illegal if it is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or has both wenMem and renMem set; no bus request SHALL be issued, and the FSM SHALL go straight to WB with w_err_o=1 and w_wenReg_o=0.
REQ-019 SHALL drive rsp_ready_o=1 only in RESP; on rsp_valid_i & rsp_ready_o, it SHALL capture the response and go to WB.
REQ-020 SHALL form load data as rsp_rdata_i >> (8*addr[1:0]), truncated to byte/half/word per mask, then sign-extended if is_load_signed else zero-extended.
REQ-021 SHALL, for a store, set w_data_o=0 and pass w_wenReg_o through as registered.
REQ-022 SHALL, if rsp_err_i=1, set w_err_o=1, force w_wenReg_o=0 and set w_data_o=0.
REQ-023 SHALL, in WB, hold w_valid_o=1 with stable w_* until w_ready_i=1, then return to IDLE; a new op SHALL NOT be accepted in the WB-handshake cycle.
REQ-024 SHALL NOT let w_* change while w_valid_o=1 and w_ready_i=0.
REQ-025 SHALL ignore rsp_valid_i outside RESP and req_ready_i outside REQ.
REQ-026 SHALL have a minimum latency of accept to w_valid_o of 1 cycle for ALU/illegal ops, and 3 cycles for memory ops with zero-wait req/rsp.

Reset
REQ-027 SHALL, while rst_i=1, immediately force state IDLE and m_ready_o=0, with req_valid_o, rsp_ready_o, w_valid_o and all data outputs 0.
REQ-028 SHALL abandon any in-flight transaction on reset, without replay.
REQ-029 SHALL enter IDLE with m_ready_o=1 on the first clock edge after rst_i falls.

Verification
REQ-030 ALU op: accept res=0x1234, rd=5, wenReg=1 -> next cycle w_valid_o=1, w_data_o=0x00001234, w_rd_o=5; holds 3 cycles under w_ready_i=0.
REQ-031 Signed byte load: addr=0x80000003, mask=0001, rsp_rdata_i=0x80FFFFFF -> w_data_o=0xFFFFFF80; unsigned -> 0x00000080.
REQ-032 Half store: addr=0x80000002, src1=0xABCD, req_ready_i low 2 cycles -> req_* stable throughout, wstrb=1100, wdata=0xABCD0000, req_wen_o=1.
REQ-033 Misaligned word load: addr=0x80000001, mask=1111 -> no req_valid_o, next cycle w_err_o=1, w_wenReg_o=0.
REQ-034 Response error on load -> w_err_o=1, w_wenReg_o=0; FSM returns to IDLE after w_ready_i.
REQ-035 rst_i asserted during RESP -> rsp_ready_o and w_valid_o drop the same cycle; late rsp_valid_i is ignored; the next op completes normally.
